period_capture: RTL and testbench

PERIOD_CAPTURE -- requirements
Module: period_capture

---
 rtl/period_capture_pkg.sv | 14 +
 rtl/period_capture_sync_edge_detect.sv | 59 +++++
 rtl/period_capture.sv | 108 ++++++++++
 tb/tb_period_capture.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/period_capture_pkg.sv
// Shared types and constants for the period_capture block.
package period_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  localparam int unsigned MIN_SYNC_STAGES = 2;
  localparam int unsigned FILTER_DEPTH    = 3;
  localparam int unsigned PRESCALE_W      = 16;

endpackage

// File: rtl/period_capture_sync_edge_detect.sv
// Synchronizer, optional glitch filter (PERIOD_CAPTURE_FILTER_EN) and rising-edge detector.
// rise_c is a one-clock pulse, combinational from the registered pipeline.
module sync_edge_detect
  import period_capture_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic event_in,
  output logic rise_c
);

  localparam int unsigned STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  logic [STAGES-1:0] sync;
  logic              synced;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[STAGES-2:0], event_in};
  end

  assign synced = sync[STAGES-1];

`ifdef PERIOD_CAPTURE_FILTER_EN
  // Level only changes once FILTER_DEPTH consecutive synchronized samples agree.
  logic [FILTER_DEPTH-2:0] hist;
  logic                    level;
  logic                    all_high;
  logic                    all_low;

  assign all_high = synced & (&hist);
  assign all_low  = ~synced & ~(|hist);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist  <= '0;
      level <= 1'b0;
    end else begin
      hist <= {hist[FILTER_DEPTH-3:0], synced};
      if (all_high)     level <= 1'b1;
      else if (all_low) level <= 1'b0;
    end
  end

  assign rise_c = all_high & ~level;
`else
  logic prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) prev <= 1'b0;
    else        prev <= synced;
  end

  assign rise_c = synced & ~prev;
`endif

endmodule

// File: rtl/period_capture.sv
// Measures prescaled ticks between qualified rising edges of event_in.
// Optional input glitch filter enabled by defining PERIOD_CAPTURE_FILTER_EN.
module period_capture
  import period_capture_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescaler,
  input  logic                  event_in,
  input  logic                  ack,
  output logic [WIDTH-1:0]      capture,
  output logic                  valid,
  output logic                  overflow,
  output logic                  overrun
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  state_e                  state, state_next;
  logic [PRESCALE_W-1:0]   pcnt, pcnt_next;
  logic [WIDTH-1:0]        count, count_next;
  logic [WIDTH-1:0]        capture_next;
  logic                    valid_next, overflow_next, overrun_next;
  logic                    rise_c;
  logic                    tick_c;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge (
    .clock    (clock),
    .reset    (reset),
    .event_in (event_in),
    .rise_c   (rise_c)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      pcnt     <= '0;
      count    <= '0;
      capture  <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_next;
      pcnt     <= pcnt_next;
      count    <= count_next;
      capture  <= capture_next;
      valid    <= valid_next;
      overflow <= overflow_next;
      overrun  <= overrun_next;
    end
  end

  // Next-state and datapath; a capture takes precedence over a coincident ack or tick.
  always_comb begin
    state_next    = state;
    pcnt_next     = pcnt;
    count_next    = count;
    capture_next  = capture;
    valid_next    = valid;
    overflow_next = overflow;
    overrun_next  = overrun;
    tick_c        = (state != ST_IDLE) && (pcnt == prescaler);

    if (ack && valid) begin
      valid_next   = 1'b0;
      overrun_next = 1'b0;
    end

    if (!enable) begin
      state_next   = ST_IDLE;
      pcnt_next    = '0;
      count_next   = '0;
      valid_next   = 1'b0;
      overrun_next = 1'b0;
    end else begin
      if (state != ST_IDLE) pcnt_next = tick_c ? '0 : pcnt + PRESCALE_W'(1);
      case (state)
        ST_IDLE: state_next = ST_ARM;
        ST_ARM: begin
          if (rise_c) begin
            state_next = ST_MEASURE;
            count_next = '0;
          end
        end
        ST_MEASURE: begin
          if (rise_c) begin
            capture_next  = count;
            overflow_next = (count == COUNT_MAX);
            valid_next    = 1'b1;
            count_next    = '0;
            overrun_next  = (valid && !ack) ? 1'b1 : overrun;
          end else if (tick_c && (count != COUNT_MAX)) begin
            count_next = count + WIDTH'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_period_capture.sv
// Randomized and directed bench for period_capture against a behavioural model.
module tb_period_capture;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned SYNC_STAGES = 2;
`ifdef PERIOD_CAPTURE_FILTER_EN
  localparam int unsigned QUAL = 3;
`else
  localparam int unsigned QUAL = 1;
`endif
  localparam int CMAX = (1 << WIDTH) - 1;
  localparam int LAT  = int'(SYNC_STAGES) + int'(QUAL) - 1;

  logic             clock    = 1'b0;
  logic             reset    = 1'b1;
  logic             enable   = 1'b0;
  logic [15:0]      prescaler = 16'd0;
  logic             event_in = 1'b0;
  logic             ack      = 1'b0;
  logic [WIDTH-1:0] capture;
  logic             valid, overflow, overrun;

  period_capture #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clock(clock), .reset(reset), .enable(enable), .prescaler(prescaler),
    .event_in(event_in), .capture(capture), .valid(valid), .ack(ack),
    .overflow(overflow), .overrun(overrun)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  // Behavioural model state
  int m_capture, m_count, m_active;
  bit m_valid, m_overflow, m_overrun, m_running, m_measuring, m_level;
  bit samples[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_capture = 0; m_count = 0; m_active = 0;
    m_valid = 0; m_overflow = 0; m_overrun = 0;
    m_running = 0; m_measuring = 0; m_level = 0;
    samples.delete();
    for (int i = 0; i < int'(SYNC_STAGES + QUAL); i++) samples.push_back(1'b0);
  endtask

  // Effect of the coming rising clock edge given the inputs currently applied.
  task automatic model_update();
    bit all1, all0, rise, tick, cap;
    int base;
    if (!reset) begin model_reset(); return; end
    base = samples.size() - int'(SYNC_STAGES);
    all1 = 1; all0 = 1;
    for (int i = 0; i < int'(QUAL); i++) begin
      if (samples[base - i]) all0 = 0; else all1 = 0;
    end
    rise = all1 && !m_level;
    if (all1) m_level = 1; else if (all0) m_level = 0;
    samples.push_back(event_in);
    void'(samples.pop_front());
    if (!enable) begin
      m_running = 0; m_measuring = 0; m_active = 0; m_count = 0;
      m_valid = 0; m_overrun = 0;
      return;
    end
    tick = m_running && ((m_active % (int'(prescaler) + 1)) == int'(prescaler));
    cap  = m_measuring && rise;
    if (cap) begin
      if (m_valid && !ack) m_overrun = 1;
      m_capture = m_count; m_overflow = (m_count == CMAX); m_valid = 1; m_count = 0;
    end else if (ack && m_valid) begin
      m_valid = 0; m_overrun = 0;
    end
    if (m_measuring && !rise && tick && m_count < CMAX) m_count++;
    if (m_running && !m_measuring && rise) begin m_measuring = 1; m_count = 0; end
    if (m_running) m_active++; else m_running = 1;
  endtask

  task automatic compare_all();
    check("capture",  32'(capture),  32'(m_capture));
    check("valid",    32'(valid),    32'(m_valid));
    check("overflow", 32'(overflow), 32'(m_overflow));
    check("overrun",  32'(overrun),  32'(m_overrun));
  endtask

  task automatic step();
    model_update();
    @(negedge clock);
    compare_all();
  endtask

  task automatic pulse(input int hi, input int lo);
    event_in = 1; repeat (hi) step();
    event_in = 0; repeat (lo) step();
  endtask

  task automatic rstep();
    ack = ($urandom_range(0, 7) == 0);
    step();
  endtask

  initial begin
    int hi, lo;
    model_reset();
    #1 reset = 0;
    repeat (2) @(negedge clock);
    check("reset_capture", 32'(capture), 0);
    check("reset_valid", 32'(valid), 0);
    check("reset_overflow", 32'(overflow), 0);
    check("reset_overrun", 32'(overrun), 0);
    reset = 1;
    repeat (3) step();

    // prescaler 3, edges 40 clocks apart
    prescaler = 16'd3; enable = 1; step();
    pulse(5, 35);
    check("arm_edge_no_valid", 32'(valid), 0);
    pulse(5, 35);
    check("p3_capture", 32'(capture), 10);
    check("p3_valid", 32'(valid), 1);
    check("p3_overflow", 32'(overflow), 0);

    // saturation with prescaler 0, edges 300 apart
    enable = 0; prescaler = 16'd0; step();
    enable = 1; step();
    pulse(5, 295);
    pulse(5, 295);
    check("sat_capture", 32'(capture), 255);
    check("sat_overflow", 32'(overflow), 1);

    // overwrite without ack, then ack clears
    enable = 0; step();
    enable = 1; step();
    pulse(4, 16);
    pulse(4, 21);
    check("first_capture", 32'(capture), 19);
    check("first_overflow", 32'(overflow), 0);
    check("first_overrun", 32'(overrun), 0);
    pulse(4, 16);
    check("overwrite_capture", 32'(capture), 24);
    check("overwrite_overrun", 32'(overrun), 1);
    ack = 1; step(); ack = 0; step();
    check("ack_valid", 32'(valid), 0);
    check("ack_overrun", 32'(overrun), 0);

    // ack coincident with a new capture
    pulse(4, 23);
    check("pre_coincident_valid", 32'(valid), 1);
    event_in = 1;
    repeat (LAT) step();
    ack = 1; step(); ack = 0;
    check("coincident_valid", 32'(valid), 1);
    check("coincident_overrun", 32'(overrun), 0);
    check("coincident_capture", 32'(capture), 26);
    step(); event_in = 0;
    repeat (10) step();

    // enable drop mid-measure
    enable = 0; step();
    check("disable_valid", 32'(valid), 0);
    check("disable_capture", 32'(capture), 26);
    enable = 1; step();
    pulse(4, 16);
    check("reenable_arm_only", 32'(valid), 0);
    pulse(4, 16);
    check("reenable_capture", 32'(capture), 19);
    check("pre_reset_valid", 32'(valid), 1);

    // asynchronous reset between clock edges
    repeat (3) step();
    model_update();
    @(posedge clock);
    #2 reset = 0;
    #1;
    check("async_capture", 32'(capture), 0);
    check("async_valid", 32'(valid), 0);
    check("async_overflow", 32'(overflow), 0);
    check("async_overrun", 32'(overrun), 0);
    model_reset();
    @(negedge clock);
    compare_all();
    repeat (2) step();
    reset = 1; step();
    pulse(4, 16);
    check("post_reset_arm_only", 32'(valid), 0);
`ifdef PERIOD_CAPTURE_FILTER_EN
    event_in = 1; repeat (2) step();
    event_in = 0; repeat (20) step();
    check("glitch_rejected", 32'(valid), 0);
`endif

    // randomized segments
    for (int seg = 0; seg < 70; seg++) begin
      if ($urandom_range(0, 3) == 0) begin
        enable = 0; prescaler = 16'($urandom_range(0, 5)); rstep();
        enable = 1;
      end
      hi = $urandom_range(1, 6);
      lo = $urandom_range(1, 40);
      event_in = 1; repeat (hi) rstep();
      event_in = 0; repeat (lo) rstep();
    end
    ack = 0;
    repeat (5) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
